// File: rtl/weights_fetch.sv
// rtl/weights_fetch.sv - weights ROM read master delivering one kernel as a valid/ready stream
module weights_fetch #(
    parameter int PARA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 25,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_r_en,
    output logic [ADDR_WIDTH-1:0] rom_raddr,
    input  logic [PARA_WIDTH-1:0] rom_dout,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [PARA_WIDTH-1:0] w_data,
    output logic [ADDR_WIDTH-1:0] w_index,
    output logic                  w_last
);

    // One extra counter bit so the counter can reach KERNEL_SIZE (up to 32)
    // and stop there without wrapping back onto a valid ROM address.
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] KS_CNT   = CNT_WIDTH'(KERNEL_SIZE);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] addr;
    logic                 accept;

    assign accept    = w_valid && w_ready;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rom_raddr = addr[ADDR_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ROM read enable; a read happens only when the output
    // buffer is empty or being emptied this cycle, so no word is ever dropped.
    always_comb begin
        state_nxt = state;
        rom_r_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                rom_r_en = (addr < KS_CNT) && (!w_valid || w_ready);
                if (accept && w_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Address counter and single-entry output buffer; the buffer only loads
    // on a ROM read, so it holds steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            w_valid <= 1'b0;
            w_data  <= '0;
            w_index <= '0;
            w_last  <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                addr <= '0;
            end
            if (rom_r_en) begin
                w_data  <= rom_dout;
                w_index <= addr[ADDR_WIDTH-1:0];
                w_last  <= (addr == LAST_CNT);
                w_valid <= 1'b1;
                addr    <= addr + 1'b1;
            end else if (accept) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weights_fetch.sv
// tb/tb_weights_fetch.sv - randomized self-checking bench for weights_fetch
module tb_weights_fetch;

    localparam int KS = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       w_ready = 1'b1;

    logic       a_busy, a_done, a_rom_r_en, a_w_valid, a_w_last;
    logic [4:0] a_rom_raddr, a_w_index;
    logic [7:0] a_rom_dout, a_w_data;

    logic       b_busy, b_done, b_rom_r_en, b_w_valid, b_w_last;
    logic [4:0] b_rom_raddr, b_w_index;
    logic [7:0] b_rom_dout, b_w_data;

    int total = 0;
    int bad = 0;
    int dut_done_cnt = 0;
    int ready_mode = 0;
    int ready_step = 0;

    // model: phase 0 idle, 1 fetching, 2 done pulse; words issued/accepted
    int m_phase = 0;
    int m_iss = 0;
    int m_acc = 0;

    always #5 clk = ~clk;

    assign a_rom_dout = {3'b000, a_rom_raddr} + 8'h10;
    assign b_rom_dout = (b_rom_raddr == 5'd0) ? 8'hA5 : 8'hEE;

    weights_fetch #(.PARA_WIDTH(8), .KERNEL_SIZE(KS), .ADDR_WIDTH(5)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(a_busy), .done(a_done),
        .rom_r_en(a_rom_r_en), .rom_raddr(a_rom_raddr), .rom_dout(a_rom_dout),
        .w_valid(a_w_valid), .w_ready(w_ready), .w_data(a_w_data),
        .w_index(a_w_index), .w_last(a_w_last)
    );

    weights_fetch #(.PARA_WIDTH(8), .KERNEL_SIZE(1), .ADDR_WIDTH(5)) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(b_busy), .done(b_done),
        .rom_r_en(b_rom_r_en), .rom_raddr(b_rom_raddr), .rom_dout(b_rom_dout),
        .w_valid(b_w_valid), .w_ready(w_ready), .w_data(b_w_data),
        .w_index(b_w_index), .w_last(b_w_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts words read and words handed over.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_iss = 0;
            m_acc = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_iss = 0;
                    m_acc = 0;
                end
                1: begin
                    automatic bit vld = (m_iss > m_acc);
                    automatic bit rd  = (m_iss < KS) && (!vld || w_ready);
                    if (vld && w_ready) m_acc++;
                    if (rd) m_iss++;
                    if (m_acc == KS) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", a_busy, 0);
            chk("rst_done", a_done, 0);
            chk("rst_valid", a_w_valid, 0);
            chk("rst_r_en", a_rom_r_en, 0);
            chk("rst_raddr", a_rom_raddr, 0);
            chk("rst_data", a_w_data, 0);
            chk("rst_index", a_w_index, 0);
            chk("rst_last", a_w_last, 0);
        end else begin
            automatic bit vld = (m_phase == 1) && (m_iss > m_acc);
            automatic bit rd  = (m_phase == 1) && (m_iss < KS) && (!vld || w_ready);
            chk("busy", a_busy, m_phase != 0);
            chk("done", a_done, m_phase == 2);
            chk("valid", a_w_valid, vld);
            chk("r_en", a_rom_r_en, rd);
            chk("raddr", a_rom_raddr, m_iss[4:0]);
            if (vld) begin
                chk("data", a_w_data, (m_acc + 16) & 8'hFF);
                chk("index", a_w_index, m_acc[4:0]);
                chk("last", a_w_last, m_acc == KS - 1);
            end
            if (b_rom_r_en) chk("k1_raddr", b_rom_raddr, 0);
            if (a_done) dut_done_cnt++;
        end
    end

    // Consumer ready generator.
    always @(negedge clk) begin
        #1;
        case (ready_mode)
            0: w_ready = 1'b1;
            1: w_ready = (ready_step % 4 == 0) || (ready_step % 4 == 3);
            default: w_ready = ($urandom_range(0, 2) != 0);
        endcase
        ready_step++;
    end

    task automatic pulse_start();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_phase == 0) break;
        end
        chk("idle_timeout", m_phase == 0, 1);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_acc >= n) break;
        end
        chk("acc_timeout", m_acc >= n, 1);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // directed ready-high run with literal timing
        ready_mode = 0;
        d0 = dut_done_cnt;
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        chk("c1_r_en", a_rom_r_en, 1);
        chk("c1_raddr", a_rom_raddr, 0);
        chk("k1_c1_r_en", b_rom_r_en, 1);
        for (int cyc = 2; cyc <= KS + 3; cyc++) begin
            @(negedge clk); #1;
            if (cyc == 2) begin
                chk("c2_valid", a_w_valid, 1);
                chk("c2_data", a_w_data, 8'h10);
                chk("c2_index", a_w_index, 0);
                chk("k1_data", b_w_data, 8'hA5);
                chk("k1_index", b_w_index, 0);
                chk("k1_last", b_w_last, 1);
                chk("k1_valid", b_w_valid, 1);
            end
            if (cyc == 3) chk("k1_done", b_done, 1);
            if (cyc == 4) chk("k1_busy_low", b_busy, 0);
            if (cyc == KS + 1) begin
                chk("last_data", a_w_data, 8'h28);
                chk("last_index", a_w_index, 24);
                chk("last_flag", a_w_last, 1);
            end
            if (cyc == KS + 2) chk("done_cycle", a_done, 1);
            if (cyc == KS + 3) chk("busy_low", a_busy, 0);
        end
        chk("done_count1", dut_done_cnt - d0, 1);

        // backpressure 1,0,0,1 with ignored starts at beat 10 and in done
        ready_mode = 1;
        d0 = dut_done_cnt;
        pulse_start();
        wait_acc(10);
        #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_phase == 2) break;
        end
        #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        chk("start_in_done_ignored", a_busy, 0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("done_count2", dut_done_cnt - d0, 1);

        // random backpressure with mid-fetch async reset
        ready_mode = 2;
        d0 = dut_done_cnt;
        pulse_start();
        wait_acc(12);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", a_w_valid, 0);
        chk("arst_busy", a_busy, 0);
        chk("arst_r_en", a_rom_r_en, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk("arst_no_done", dut_done_cnt - d0, 0);
        pulse_start();
        wait_idle();
        chk("done_count3", dut_done_cnt - d0, 1);

        // several random kernels
        for (int k = 0; k < 3; k++) begin
            pulse_start();
            wait_idle();
        end

        // back-to-back kernels, one idle cycle between
        ready_mode = 0;
        d0 = dut_done_cnt;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (a_done) break;
        end
        @(negedge clk); #1;
        chk("b2b_gap_idle", a_busy, 0);
        start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        chk("b2b_busy", a_busy, 1);
        chk("b2b_raddr0", a_rom_raddr, 0);
        wait_idle();
        chk("done_count4", dut_done_cnt - d0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/weights_fetch.md
Name: weights_fetch

Overview:
- Read-side master for a weights ROM: walks ROM addresses 0..KERNEL_SIZE-1 through the ROM read port (read enable, 5-bit read address, combinational data).
- Delivers each kernel weight to the convolution engine as a valid/ready stream with an index and a last flag.
- Sits between one weights ROM instance and one conv kernel register bank; one instance per ROM.

Parameters:
- PARA_WIDTH, `CNN_PARA_WIDTH, width of one weight word.
- KERNEL_SIZE, `CNN_KERNEL_SIZE, number of weights per kernel; legal range 1..32.
- ADDR_WIDTH, 5, ROM address width; fixed to match the ROM read port.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to fetch a full kernel; ignored unless idle.
- busy  output  1  high while a fetch is in progress (state != IDLE).
- done  output  1  registered one-cycle pulse after the last weight is accepted.
- rom_r_en  output  1  ROM read enable; combinational from state and handshake.
- rom_raddr  output  ADDR_WIDTH  ROM read address; driven from the address counter.
- rom_dout  input  PARA_WIDTH  ROM data; valid in the same cycle as rom_r_en/rom_raddr.
- w_valid  output  1  output weight valid.
- w_ready  input  1  consumer ready.
- w_data  output  PARA_WIDTH  weight value.
- w_index  output  ADDR_WIDTH  ROM address the current w_data came from.
- w_last  output  1  high with the weight at index KERNEL_SIZE-1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, addr counter=0, rom_r_en=0, rom_raddr=0.
  - w_valid=0, w_data=0, w_index=0, w_last=0.
  - done=0, busy=0.
- States: IDLE, FETCH, DONE.
  - IDLE: start=1 -> FETCH, addr counter cleared to 0. start=0 -> stay.
  - FETCH: rom_r_en = (addr < KERNEL_SIZE) && (!w_valid || w_ready).
    - When rom_r_en=1, at the clock edge: w_data<=rom_dout, w_index<=addr, w_last<=(addr==KERNEL_SIZE-1), w_valid<=1, addr<=addr+1.
    - When w_valid && w_ready && no new read: w_valid<=0.
    - When the handshake accepts the word with w_last=1 -> DONE, w_valid<=0, w_last<=0.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Output register: single-entry buffer. w_data, w_index and w_last hold stable while w_valid=1 and w_ready=0; no word is dropped or duplicated.
- Timing, with start sampled at edge 0 and w_ready held high:
  - rom_r_en=1 with raddr=0 in cycle 1.
  - w_valid=1 with index 0 in cycle 2.
  - One weight per cycle thereafter; last weight in cycle KERNEL_SIZE+1.
  - done=1 in cycle KERNEL_SIZE+2; busy low again in cycle KERNEL_SIZE+3.
- rom_raddr always equals the addr counter. The counter never exceeds KERNEL_SIZE and is not wrapped; rom_r_en is never asserted for an address >= KERNEL_SIZE.
- start while busy (FETCH or DONE): ignored, no restart.
- start in the same cycle done is high: ignored. A new start is accepted only in IDLE.
- KERNEL_SIZE=1: the single weight carries w_last=1; done follows its acceptance.
- Reset mid-fetch: all state returns to reset values immediately (asynchronous); the partial kernel is discarded with no done pulse.
- Backpressure: w_ready=0 holds rom_r_en=0 while w_valid=1. rom_dout is sampled only in cycles where rom_r_en=1.

Test Plan:
- Basic fetch, KERNEL_SIZE=25, PARA_WIDTH=8, ROM file rom[i]=i+8'h10, start pulse, w_ready=1 -> 25 consecutive w_valid beats with data 8'h10..8'h28, w_index 0..24, w_last only on index 24, done in the cycle after beat 24, busy=0 the next cycle.
- Backpressure: w_ready toggles 1,0,0,1 repeating -> the same 25-word sequence in order, no repeats or gaps, w_data stable during every stall, rom_r_en=0 in every stall cycle.
- start asserted again at beat 10 and in the DONE cycle -> ignored; exactly one 25-word sequence and one done pulse.
- rst asserted asynchronously mid-cycle at beat 12 -> w_valid, busy and rom_r_en drop without waiting for a clock edge, no done pulse; a following start yields a full sequence from index 0, data 8'h10.
- KERNEL_SIZE=1 build with rom[0]=8'hA5 -> one beat with w_data=8'hA5, w_index=0, w_last=1, then done; rom_raddr never exceeds 0 while rom_r_en=1.
- Back-to-back kernels: start in the first IDLE cycle after done -> second sequence identical to the first, a gap of exactly one idle cycle.
